// File: rtl/blackjack_pkg.sv
// Shared types and card arithmetic for the multi-seat blackjack table controller.
package blackjack_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEAL,
      S_PLAYER_TURN,
      S_PLAYER_DRAW,
      S_DEALER_DRAW,
      S_DEALER_TURN,
      S_SETTLE,
      S_DONE
   } state_e;

   typedef logic [3:0] card_rank_t;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_WIN,
      RES_LOSE,
      RES_TIE
   } result_e;

   localparam int TOTAL_W   = 8;
   localparam int BLACKJACK = 21;

   // Aces count 1 here; the soft upgrade happens in best_total. Invalid ranks count as 10.
   function automatic logic [3:0] card_value(card_rank_t rank);
      if (rank >= 4'd1 && rank <= 4'd10) return rank;
      return 4'd10;
   endfunction

   function automatic logic [TOTAL_W-1:0] best_total(logic [TOTAL_W-1:0] hard, logic ace);
      if (ace && hard <= 8'd11) return hard + 8'd10;
      return hard;
   endfunction

endpackage

// File: rtl/bj_hand_acc.sv
// One hand accumulator: saturating hard total, ace flag and best total for a seat or the dealer.
module bj_hand_acc
   import blackjack_pkg::*;
#(
   parameter int HAND_W = 5
)(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              clear_i,
   input  logic              add_i,
   input  card_rank_t        card_i,
   output logic [HAND_W-1:0] hard_o,
   output logic              ace_o,
   output logic [HAND_W-1:0] best_o
);

   localparam logic [HAND_W-1:0] HAND_MAX = '1;

   logic [HAND_W-1:0] hard_q, hard_d;
   logic              ace_q, ace_d;
   logic [HAND_W:0]   sum;

   always_comb begin
      sum    = {1'b0, hard_q} + (HAND_W+1)'(card_value(card_i));
      hard_d = hard_q;
      ace_d  = ace_q;
      if (clear_i) begin
         hard_d = '0;
         ace_d  = 1'b0;
      end else if (add_i) begin
         hard_d = sum[HAND_W] ? HAND_MAX : sum[HAND_W-1:0];
         ace_d  = ace_q | (card_i == 4'd1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hard_q <= '0;
         ace_q  <= 1'b0;
      end else begin
         hard_q <= hard_d;
         ace_q  <= ace_d;
      end
   end

   assign hard_o = hard_q;
   assign ace_o  = ace_q;
   assign best_o = HAND_W'(best_total(TOTAL_W'(hard_q), ace_q));

endmodule

// File: rtl/blackjack_table_ctrl.sv
// Multi-seat blackjack round controller: deal, seat turns, dealer play, settlement.
// Define DEALER_HIT_SOFT17_EN to make the dealer draw on a soft total equal to DEALER_STAND.
module blackjack_table_ctrl
   import blackjack_pkg::*;
#(
   parameter  int NUM_PLAYERS  = 4,
   parameter  int HAND_W       = 5,
   parameter  int DEALER_STAND = 17,
   localparam int SEAT_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          shuffle_ok,
   output logic                          card_req,
   input  logic                          card_valid,
   input  logic [3:0]                    card_in,
   input  logic [NUM_PLAYERS-1:0]        hit,
   input  logic [NUM_PLAYERS-1:0]        stay,
   output logic [SEAT_W-1:0]             active_seat,
   output logic [NUM_PLAYERS*HAND_W-1:0] player_hand,
   output logic [HAND_W-1:0]             dealer_hand,
   output logic [NUM_PLAYERS-1:0]        win,
   output logic [NUM_PLAYERS-1:0]        lose,
   output logic [NUM_PLAYERS-1:0]        tie,
   output logic                          round_done
);

   localparam int                DEAL_CARDS = 2 * (NUM_PLAYERS + 1);
   localparam int                CNT_W      = $clog2(DEAL_CARDS + 1);
   localparam logic [HAND_W-1:0] BJ         = HAND_W'(BLACKJACK);
   localparam logic [HAND_W-1:0] STAND      = HAND_W'(DEALER_STAND);
   localparam logic [SEAT_W-1:0] LAST_SEAT  = SEAT_W'(NUM_PLAYERS - 1);
   localparam logic [CNT_W-1:0]  LAST_DEAL  = CNT_W'(DEAL_CARDS - 1);
   localparam logic [CNT_W-1:0]  ROW        = CNT_W'(NUM_PLAYERS + 1);

   state_e                  state_q, state_d;
   logic                    card_req_q, card_req_d;
   logic [CNT_W-1:0]        deal_cnt_q, deal_cnt_d, deal_pos;
   logic [SEAT_W-1:0]       seat_q, seat_d;
   logic [NUM_PLAYERS-1:0]  win_q, win_d, lose_q, lose_d, tie_q, tie_d;
   logic                    take, clear_hands, d_add, dealer_hits;
   logic [NUM_PLAYERS-1:0]  p_add, p_ace, p_bust;
   logic [HAND_W-1:0]       p_hard [NUM_PLAYERS];
   logic [HAND_W-1:0]       p_best [NUM_PLAYERS];
   logic [HAND_W-1:0]       d_hard, d_best;
   logic                    d_ace;
   logic                    unused_flags;
   result_e                 res;

   function automatic result_e settle_seat(logic [HAND_W-1:0] p, logic [HAND_W-1:0] d);
      if (p > BJ) return RES_LOSE;
      if (d > BJ) return RES_WIN;
      if (p > d)  return RES_WIN;
      if (p < d)  return RES_LOSE;
      return RES_TIE;
   endfunction

   assign take     = card_req_q & card_valid;
   assign deal_pos = (deal_cnt_q >= ROW) ? deal_cnt_q - ROW : deal_cnt_q;
   assign d_add    = take && ((state_q == S_DEAL && deal_pos == CNT_W'(NUM_PLAYERS)) ||
                              state_q == S_DEALER_DRAW);

   for (genvar s = 0; s < NUM_PLAYERS; s++) begin : g_seat
      assign p_add[s] = take && ((state_q == S_DEAL && deal_pos == CNT_W'(s)) ||
                                 (state_q == S_PLAYER_DRAW && seat_q == SEAT_W'(s)));
      bj_hand_acc #(.HAND_W(HAND_W)) u_hand (
         .clk_i   (clk),
         .reset_i (reset),
         .clear_i (clear_hands),
         .add_i   (p_add[s]),
         .card_i  (card_in),
         .hard_o  (p_hard[s]),
         .ace_o   (p_ace[s]),
         .best_o  (p_best[s])
      );
      assign p_bust[s] = p_hard[s] > BJ;
      assign player_hand[s*HAND_W +: HAND_W] = p_best[s];
   end

   bj_hand_acc #(.HAND_W(HAND_W)) u_dealer (
      .clk_i   (clk),
      .reset_i (reset),
      .clear_i (clear_hands),
      .add_i   (d_add),
      .card_i  (card_in),
      .hard_o  (d_hard),
      .ace_o   (d_ace),
      .best_o  (d_best)
   );

`ifdef DEALER_HIT_SOFT17_EN
   assign dealer_hits = (d_best < STAND) ||
                        (d_best == STAND && d_ace && d_hard <= HAND_W'(11));
`else
   assign dealer_hits = d_best < STAND;
`endif

   assign unused_flags = ^{p_ace, d_ace, d_hard};

   always_comb begin
      state_d     = state_q;
      card_req_d  = 1'b0;
      deal_cnt_d  = deal_cnt_q;
      seat_d      = seat_q;
      win_d       = win_q;
      lose_d      = lose_q;
      tie_d       = tie_q;
      clear_hands = 1'b0;
      res         = RES_NONE;
      case (state_q)
         S_IDLE: begin
            if (shuffle_ok) begin
               clear_hands = 1'b1;
               win_d       = '0;
               lose_d      = '0;
               tie_d       = '0;
               deal_cnt_d  = '0;
               seat_d      = '0;
               card_req_d  = 1'b1;
               state_d     = S_DEAL;
            end
         end
         // card_req drops for one cycle after every accepted card
         S_DEAL: begin
            card_req_d = !take;
            if (take) begin
               if (deal_cnt_q == LAST_DEAL) state_d = S_PLAYER_TURN;
               else                         deal_cnt_d = deal_cnt_q + 1'b1;
            end
         end
         S_PLAYER_TURN: begin
            if (p_best[seat_q] >= BJ || stay[seat_q]) begin
               if (seat_q == LAST_SEAT) state_d = (&p_bust) ? S_SETTLE : S_DEALER_TURN;
               else                     seat_d  = seat_q + 1'b1;
            end else if (hit[seat_q]) begin
               card_req_d = 1'b1;
               state_d    = S_PLAYER_DRAW;
            end
         end
         S_PLAYER_DRAW: begin
            card_req_d = !take;
            if (take) state_d = S_PLAYER_TURN;
         end
         S_DEALER_TURN: begin
            if (dealer_hits) begin
               card_req_d = 1'b1;
               state_d    = S_DEALER_DRAW;
            end else begin
               state_d = S_SETTLE;
            end
         end
         S_DEALER_DRAW: begin
            card_req_d = !take;
            if (take) state_d = S_DEALER_TURN;
         end
         S_SETTLE: begin
            for (int s = 0; s < NUM_PLAYERS; s++) begin
               res       = settle_seat(p_best[s], d_best);
               win_d[s]  = (res == RES_WIN);
               lose_d[s] = (res == RES_LOSE);
               tie_d[s]  = (res == RES_TIE);
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         card_req_q <= 1'b0;
         deal_cnt_q <= '0;
         seat_q     <= '0;
         win_q      <= '0;
         lose_q     <= '0;
         tie_q      <= '0;
      end else begin
         state_q    <= state_d;
         card_req_q <= card_req_d;
         deal_cnt_q <= deal_cnt_d;
         seat_q     <= seat_d;
         win_q      <= win_d;
         lose_q     <= lose_d;
         tie_q      <= tie_d;
      end
   end

   assign card_req    = card_req_q;
   assign active_seat = (state_q == S_PLAYER_TURN) ? seat_q : '0;
   assign dealer_hand = d_best;
   assign win         = win_q;
   assign lose        = lose_q;
   assign tie         = tie_q;
   assign round_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_blackjack_table_ctrl.sv
// Scoreboard bench for blackjack_table_ctrl: a card server, a threshold seat policy and a round model.
module tb_blackjack_table_ctrl;

   localparam int NP    = 4;
   localparam int HW    = 5;
   localparam int STAND = 17;
   localparam int SW    = 2;

   logic             clk = 1'b0;
   logic             reset, shuffle_ok, card_req, card_valid, round_done;
   logic [3:0]       card_in;
   logic [NP-1:0]    hit, stay, win, lose, tie;
   logic [SW-1:0]    active_seat;
   logic [NP*HW-1:0] player_hand;
   logic [HW-1:0]    dealer_hand;

   typedef struct {
      logic [NP*HW-1:0] ph;
      logic [HW-1:0]    dh;
      logic [NP-1:0]    w, l, t;
      int               ncards;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] deck[$];
   int         plan[64];
   int         plan_n;
   int         tgt[NP];
   int         card_delay, xfer, hi_min, hi_max, max_seat;
   int         total, bad;

   always #5 clk = ~clk;

   blackjack_table_ctrl #(.NUM_PLAYERS(NP), .HAND_W(HW), .DEALER_STAND(STAND)) dut (
      .clk         (clk),
      .reset       (reset),
      .shuffle_ok  (shuffle_ok),
      .card_req    (card_req),
      .card_valid  (card_valid),
      .card_in     (card_in),
      .hit         (hit),
      .stay        (stay),
      .active_seat (active_seat),
      .player_hand (player_hand),
      .dealer_hand (dealer_hand),
      .win         (win),
      .lose        (lose),
      .tie         (tie),
      .round_done  (round_done)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int cval(int r);
      if (r >= 1 && r <= 10) return r;
      return 10;
   endfunction

   function automatic int bestv(int h, bit a);
      return (a && h <= 11) ? h + 10 : h;
   endfunction

   function automatic int sat_add(int h, int v);
      return (h + v > 31) ? 31 : h + v;
   endfunction

   function automatic int plan_card(int idx);
      return (idx < plan_n) ? plan[idx] : 2;
   endfunction

   function automatic bit dealer_wants(int h, bit a);
      int b;
      b = bestv(h, a);
`ifdef DEALER_HIT_SOFT17_EN
      if (b == STAND && a && h <= 11) return 1'b1;
`endif
      return b < STAND;
   endfunction

   task automatic model_round();
      int   ph[NP];
      bit   pa[NP];
      int   dh, k, pb, db, r;
      bit   da, all_bust;
      exp_t e;
      k = 0; dh = 0; da = 0;
      for (int s = 0; s < NP; s++) begin ph[s] = 0; pa[s] = 0; end
      for (int p = 0; p < 2; p++) begin
         for (int s = 0; s < NP; s++) begin
            r = plan_card(k); k++;
            ph[s] = sat_add(ph[s], cval(r)); pa[s] |= (r == 1);
         end
         r = plan_card(k); k++;
         dh = sat_add(dh, cval(r)); da |= (r == 1);
      end
      for (int s = 0; s < NP; s++) begin
         while (bestv(ph[s], pa[s]) < 21 && bestv(ph[s], pa[s]) < tgt[s]) begin
            r = plan_card(k); k++;
            ph[s] = sat_add(ph[s], cval(r)); pa[s] |= (r == 1);
         end
      end
      all_bust = 1'b1;
      for (int s = 0; s < NP; s++) if (bestv(ph[s], pa[s]) <= 21) all_bust = 1'b0;
      if (!all_bust) begin
         while (dealer_wants(dh, da)) begin
            r = plan_card(k); k++;
            dh = sat_add(dh, cval(r)); da |= (r == 1);
         end
      end
      db = bestv(dh, da);
      e.dh = HW'(db); e.w = '0; e.l = '0; e.t = '0; e.ph = '0;
      for (int s = 0; s < NP; s++) begin
         pb = bestv(ph[s], pa[s]);
         e.ph[s*HW +: HW] = HW'(pb);
         if (pb > 21)      e.l[s] = 1'b1;
         else if (db > 21) e.w[s] = 1'b1;
         else if (pb > db) e.w[s] = 1'b1;
         else if (pb < db) e.l[s] = 1'b1;
         else              e.t[s] = 1'b1;
      end
      e.ncards = k;
      exp_q.push_back(e);
   endtask

   // Seat policy: hit is always offered; stay is raised once the hand reaches the seat's target.
   initial begin
      hit = '0; stay = '0;
      forever begin
         @(negedge clk);
         for (int s = 0; s < NP; s++) begin
            hit[s]  = 1'b1;
            stay[s] = (int'(player_hand[s*HW +: HW]) >= tgt[s]);
         end
      end
   end

   // Deck server: answers card_req after card_delay cycles and records request lengths.
   initial begin
      int wait_cnt, hi_len;
      card_valid = 1'b0; card_in = '0; wait_cnt = 0; hi_len = 0;
      forever begin
         @(negedge clk);
         if (int'(active_seat) > max_seat) max_seat = int'(active_seat);
         if (card_valid) begin
            card_valid = 1'b0;
            xfer++;
            if (hi_len < hi_min) hi_min = hi_len;
            if (hi_len > hi_max) hi_max = hi_len;
            hi_len = 0; wait_cnt = 0;
         end else if (card_req) begin
            hi_len++;
            if (wait_cnt >= card_delay) begin
               if (deck.size() > 0) card_in = deck.pop_front();
               else                 card_in = 4'd2;
               card_valid = 1'b1;
            end else begin
               wait_cnt++;
            end
         end else begin
            hi_len = 0; wait_cnt = 0;
         end
      end
   end

   task automatic load_plan(input int n, input int c[$]);
      plan_n = n;
      for (int i = 0; i < n; i++) plan[i] = c[i];
   endtask

   task automatic run_round(input int dly, input int hold, input string name);
      bit   seen;
      exp_t e;
      deck.delete();
      for (int i = 0; i < plan_n; i++) deck.push_back(4'(plan[i]));
      card_delay = dly; xfer = 0; hi_min = 1000; hi_max = 0; max_seat = 0;
      model_round();
      shuffle_ok = 1'b1;
      repeat (hold) @(negedge clk);
      shuffle_ok = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 5000 && !seen; c++) begin
         @(negedge clk);
         if (round_done) seen = 1'b1;
      end
      check_val({name, "_done"}, seen, 1);
      if (seen) begin
         e = exp_q.pop_front();
         check_val({name, "_player_hand"}, player_hand, e.ph);
         check_val({name, "_dealer_hand"}, dealer_hand, e.dh);
         check_val({name, "_win"}, win, e.w);
         check_val({name, "_lose"}, lose, e.l);
         check_val({name, "_tie"}, tie, e.t);
         check_val({name, "_cards"}, xfer, e.ncards);
         check_val({name, "_max_seat"}, max_seat, NP - 1);
         check_val({name, "_req_min"}, hi_min, dly + 1);
         check_val({name, "_req_max"}, hi_max, dly + 1);
         @(negedge clk);
         check_val({name, "_done_pulse"}, round_done, 0);
      end else begin
         exp_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int quiet;
      total = 0; bad = 0;
      reset = 1'b1; shuffle_ok = 1'b0;
      for (int s = 0; s < NP; s++) tgt[s] = 0;
      card_delay = 0; plan_n = 0;
      repeat (3) @(negedge clk);
      check_val("rst_card_req", card_req, 0);
      check_val("rst_player_hand", player_hand, 0);
      check_val("rst_dealer_hand", dealer_hand, 0);
      check_val("rst_results", {win, lose, tie}, 0);
      check_val("rst_round_done", round_done, 0);
      check_val("rst_active_seat", active_seat, 0);
      reset = 1'b0;
      @(negedge clk);

      // Seat0 busts on a hit, seat1 has A,K, seat3 hits to 21, dealer holds soft 17.
      load_plan(13, '{10, 1, 9, 13, 1, 6, 13, 9, 8, 6, 9, 3, 4});
      tgt = '{17, 0, 0, 19};
      run_round(0, 1, "r1");

      // Blackjack seat against dealer 20, invalid ranks, shuffle_ok held during the deal.
      load_plan(12, '{1, 0, 10, 9, 15, 13, 7, 10, 2, 10, 5, 10});
      tgt = '{0, 0, 0, 21};
      run_round(0, 3, "r2");

      // All seats bust with a slow deck: dealer must not draw.
      load_plan(14, '{10, 10, 10, 10, 10, 6, 6, 6, 6, 5, 10, 10, 10, 10});
      tgt = '{21, 21, 21, 21};
      run_round(4, 1, "r3");

      // Reset in the middle of the deal.
      plan_n = 20;
      for (int i = 0; i < 20; i++) plan[i] = 5;
      deck.delete();
      for (int i = 0; i < 20; i++) deck.push_back(4'd5);
      card_delay = 0; xfer = 0;
      shuffle_ok = 1'b1;
      @(negedge clk);
      shuffle_ok = 1'b0;
      for (int c = 0; c < 200 && xfer < 3; c++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_val("mid_card_req", card_req, 0);
      check_val("mid_player_hand", player_hand, 0);
      check_val("mid_dealer_hand", dealer_hand, 0);
      check_val("mid_results", {win, lose, tie, round_done}, 0);
      reset = 1'b0;
      quiet = 0;
      repeat (6) begin
         @(negedge clk);
         if (card_req || round_done) quiet++;
      end
      check_val("mid_idle_quiet", quiet, 0);

      for (int r = 0; r < 3; r++) begin
         plan_n = 40;
         for (int i = 0; i < 40; i++) plan[i] = $urandom_range(0, 15);
         for (int s = 0; s < NP; s++) tgt[s] = $urandom_range(12, 21);
         run_round(r, 1, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
